// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds reset defaults, FSM encoding and the IF/ID / skid bundles.
package if_fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC        = 32'd4;

    typedef enum logic {
        RUN = 1'b0,
        BUF = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } skid_t;

endpackage

// File: rtl/if_fetch_stage_pc_inc.sv
// 32-bit PC incrementer: pc + 4, wrapping modulo 2^32.
// Carry-out is intentionally dropped.
module if_fetch_stage_pc_inc
    import if_fetch_stage_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] pc4
);

    assign pc4 = pc + PC_INC;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, skid buffer and IF/ID register.
// Handles memory wait states, decode stalls and branch redirects.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_req,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_ifid_pc,
    output logic [31:0] o_ifid_pc4,
    output logic [31:0] o_ifid_instr,
    output logic        o_ifid_valid
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  pc;
    logic [31:0]  pc_nxt;
    logic [31:0]  pc4;
    ifid_t        ifid;
    ifid_t        ifid_nxt;
    skid_t        skid;
    skid_t        skid_nxt;

    if_fetch_stage_pc_inc u_pc_inc (
        .pc  (pc),
        .pc4 (pc4)
    );

    assign o_imem_addr  = pc;
    assign o_imem_req   = (state == RUN);
    assign o_ifid_pc    = ifid.pc;
    assign o_ifid_pc4   = ifid.pc4;
    assign o_ifid_instr = ifid.instr;
    assign o_ifid_valid = ifid.valid;

    // Next-state: redirect beats stall beats normal fetch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ifid_nxt  = ifid;
        skid_nxt  = skid;
        if (i_redirect) begin
            pc_nxt         = i_redirect_pc;
            ifid_nxt.valid = 1'b0;
            ifid_nxt.instr = NOP_INSTR;
            skid_nxt       = '0;
            state_nxt      = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (i_imem_ready) begin
                        pc_nxt = pc4;
                        if (i_stall) begin
                            skid_nxt  = '{pc: pc, pc4: pc4, instr: i_imem_data};
                            state_nxt = BUF;
                        end else begin
                            ifid_nxt = '{pc: pc, pc4: pc4,
                                         instr: i_imem_data, valid: 1'b1};
                        end
                    end else if (!i_stall) begin
                        ifid_nxt.valid = 1'b0;
                        ifid_nxt.instr = NOP_INSTR;
                    end
                end
                BUF: begin
                    if (!i_stall) begin
                        ifid_nxt = '{pc: skid.pc, pc4: skid.pc4,
                                     instr: skid.instr, valid: 1'b1};
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // State register: synchronous reset overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
            skid  <= '0;
            ifid  <= '{pc: 32'd0, pc4: 32'd0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            skid  <= skid_nxt;
            ifid  <= ifid_nxt;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage.
// Directed scenarios followed by a random phase against a behavioural model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_imem_addr;
    logic        o_imem_req;
    logic        i_imem_ready;
    logic [31:0] i_imem_data;
    logic [31:0] o_ifid_pc;
    logic [31:0] o_ifid_pc4;
    logic [31:0] o_ifid_instr;
    logic        o_ifid_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural view of the stage.
    logic [31:0] m_pc;
    bit          m_held;
    logic [31:0] m_held_pc;
    logic [31:0] m_held_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic [31:0] m_instr;
    logic        m_valid;

    if_fetch_stage #(
        .RESET_PC  (RPC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_addr   (o_imem_addr),
        .o_imem_req    (o_imem_req),
        .i_imem_ready  (i_imem_ready),
        .i_imem_data   (i_imem_data),
        .o_ifid_pc     (o_ifid_pc),
        .o_ifid_pc4    (o_ifid_pc4),
        .o_ifid_instr  (o_ifid_instr),
        .o_ifid_valid  (o_ifid_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  o_imem_addr, m_pc);
        check({tag, ".req"},   {31'd0, o_imem_req}, {31'd0, !m_held});
        check({tag, ".valid"}, {31'd0, o_ifid_valid}, {31'd0, m_valid});
        check({tag, ".instr"}, o_ifid_instr, m_instr);
        check({tag, ".pc"},    o_ifid_pc, m_ipc);
        check({tag, ".pc4"},   o_ifid_pc4, m_ipc4);
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input string tag, input bit r, input bit st,
                        input bit rd, input logic [31:0] tgt, input bit rdy);
        logic [31:0] data;
        data          = $urandom;
        rst           = r;
        i_stall       = st;
        i_redirect    = rd;
        i_redirect_pc = tgt;
        i_imem_ready  = rdy;
        i_imem_data   = data;
        if (r) begin
            m_pc = RPC; m_held = 0; m_valid = 0;
            m_instr = NOP; m_ipc = 0; m_ipc4 = 0;
        end else if (rd) begin
            m_pc = tgt; m_held = 0; m_valid = 0; m_instr = NOP;
        end else if (m_held) begin
            if (!st) begin
                m_ipc = m_held_pc; m_ipc4 = m_held_pc + 4;
                m_instr = m_held_instr; m_valid = 1; m_held = 0;
            end
        end else if (st) begin
            if (rdy) begin
                m_held_pc = m_pc; m_held_instr = data;
                m_pc = m_pc + 4; m_held = 1;
            end
        end else if (rdy) begin
            m_ipc = m_pc; m_ipc4 = m_pc + 4;
            m_instr = data; m_valid = 1; m_pc = m_pc + 4;
        end else begin
            m_valid = 0; m_instr = NOP;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1; i_stall = 0; i_redirect = 0;
        i_redirect_pc = 0; i_imem_ready = 0; i_imem_data = 0;
        #1;
        step("rst0", 1, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0);
        // Streaming fetch 0,4
        step("run0", 0, 0, 0, 0, 1);
        step("run4", 0, 0, 0, 0, 1);
        // Memory wait at PC=8
        for (int i = 0; i < 3; i++) step("wait8", 0, 0, 0, 0, 0);
        step("run8", 0, 0, 0, 0, 1);
        step("run12", 0, 0, 0, 0, 1);
        // Stall with ready at PC=16, then hold in BUF
        step("skid16", 0, 1, 0, 0, 1);
        step("buf_a", 0, 1, 0, 0, 1);
        step("buf_b", 0, 1, 0, 0, 0);
        step("unbuf", 0, 0, 0, 0, 0);
        step("run20", 0, 0, 0, 0, 1);
        // Redirect while stalled in BUF
        step("skid24", 0, 1, 0, 0, 1);
        step("redir", 0, 1, 1, 32'h0000_0100, 1);
        step("r100", 0, 0, 0, 0, 1);
        // Wrap-around of PC
        step("redirw", 0, 0, 1, 32'hFFFF_FFFC, 1);
        step("wrap", 0, 0, 0, 0, 1);
        step("wrap0", 0, 0, 0, 0, 1);
        // Reset while stalled in BUF
        step("skidr", 0, 1, 0, 0, 1);
        step("rstbuf", 1, 1, 0, 0, 1);
        step("postrst", 0, 0, 0, 0, 1);
        // Random phase
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                             : {$urandom, 2'b00} & 32'hFFFF_FFFC,
                 ($urandom_range(0, 99) < 70));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
